// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

  localparam int CFG_W    = 16;
  localparam int DEF_DIV  = 1000;
  localparam int DEF_HIGH = 500;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } cfg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Divisors below 2 cannot toggle, so they are treated as 2.
  function automatic logic [CFG_W-1:0] eff_div(input cfg_t c);
    return (c.div < CFG_W'(2)) ? CFG_W'(2) : c.div;
  endfunction

  function automatic logic [CFG_W-1:0] eff_phase(input cfg_t c);
    return (c.phase < eff_div(c)) ? c.phase : '0;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, run flag, active/shadow config and registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sync,
  input  logic wr,
  input  cfg_t wr_cfg,
  output logic clk_out,
  output logic rise_tick,
  output logic fall_tick,
  output logic pending
);

  localparam cfg_t RESET_CFG = '{div: CFG_W'(DEFAULT_DIV), high: CFG_W'(DEFAULT_HIGH), phase: '0};

  cfg_t             act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d, run_q, run_d;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic             wrap, apply;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q  <= RESET_CFG;
      shd_q  <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    wrap   = run_q && (cnt_q == eff_div(act_q) - CFG_W'(1));
    // Shadow config is only ever adopted at a period boundary, a stop or a sync.
    apply  = pend_q && (!run_q || !en || wrap || sync);
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (wr) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
    if (!run_q) begin
      run_d = en;
      cnt_d = en ? eff_phase(act_d) : '0;
    end else if (!en) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (sync) begin
      cnt_d = eff_phase(act_d);
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CFG_W'(1);
    end
    clk_d  = run_d && (cnt_d < act_d.high);
    rise_d = clk_d && !clk_q;
    fall_d = !clk_d && clk_q;
  end

  assign clk_out   = clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign pending   = pend_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: config handshake decode and Sync fan-out.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter  int CHANNELS     = 2,
  parameter  int CNT_W        = CFG_W,
  parameter  int DEFAULT_DIV  = DEF_DIV,
  parameter  int DEFAULT_HIGH = DEF_HIGH,
  localparam int CH_W         = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] En,
  input  logic                Sync,
  input  logic                Cfg_valid,
  output logic                Cfg_ready,
  input  logic [CH_W-1:0]     Cfg_ch,
  input  logic [CNT_W-1:0]    Cfg_div,
  input  logic [CNT_W-1:0]    Cfg_high,
  input  logic [CNT_W-1:0]    Cfg_phase,
  output logic [CHANNELS-1:0] ClkOut,
  output logic [CHANNELS-1:0] RiseTick,
  output logic [CHANNELS-1:0] FallTick,
  output logic [CHANNELS-1:0] Pending
);

  cfg_t                wr_cfg;
  logic [CHANNELS-1:0] wr;

  assign wr_cfg = '{div: CFG_W'(Cfg_div), high: CFG_W'(Cfg_high), phase: CFG_W'(Cfg_phase)};

  // Out-of-range channel numbers match nothing, so they read ready and are dropped.
  always_comb begin
    Cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (Cfg_ch == CH_W'(i)) Cfg_ready = ~Pending[i];
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign wr[gi] = Cfg_valid && Cfg_ready && (Cfg_ch == CH_W'(gi));

    clk_div_channel #(
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_ch (
      .clk      (Clk),
      .reset_n  (Reset),
      .en       (En[gi]),
      .sync     (Sync),
      .wr       (wr[gi]),
      .wr_cfg   (wr_cfg),
      .clk_out  (ClkOut[gi]),
      .rise_tick(RiseTick[gi]),
      .fall_tick(FallTick[gi]),
      .pending  (Pending[gi])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed scenarios plus random traffic against a cycle model.
`timescale 1ns/1ps
module tb_prog_clk_div;

  localparam int NCH  = 2;
  localparam int CH_W = 1;
  localparam int DDIV = 1000;
  localparam int DHI  = 500;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [NCH-1:0]  En = '0;
  logic            Sync = 1'b0;
  logic            Cfg_valid = 1'b0;
  logic            Cfg_ready;
  logic [CH_W-1:0] Cfg_ch = '0;
  logic [15:0]     Cfg_div = '0, Cfg_high = '0, Cfg_phase = '0;
  logic [NCH-1:0]  ClkOut, RiseTick, FallTick, Pending;

  int total = 0;
  int bad = 0;

  prog_clk_div #(.CHANNELS(NCH), .CNT_W(16), .DEFAULT_DIV(DDIV), .DEFAULT_HIGH(DHI)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Sync(Sync), .Cfg_valid(Cfg_valid),
    .Cfg_ready(Cfg_ready), .Cfg_ch(Cfg_ch), .Cfg_div(Cfg_div), .Cfg_high(Cfg_high),
    .Cfg_phase(Cfg_phase), .ClkOut(ClkOut), .RiseTick(RiseTick), .FallTick(FallTick),
    .Pending(Pending)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_div[NCH], m_high[NCH], m_ph[NCH], s_div[NCH], s_high[NCH], s_ph[NCH], m_q[NCH];
  bit m_pend[NCH], m_run[NCH], m_clk[NCH], m_rise[NCH], m_fall[NCH];
  bit mdl_acc = 1'b0;

  function automatic int eff_d(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  initial forever begin
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      mdl_acc = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DDIV; m_high[c] = DHI; m_ph[c] = 0;
        s_div[c] = 0; s_high[c] = 0; s_ph[c] = 0;
        m_pend[c] = 0; m_run[c] = 0; m_q[c] = 0;
        m_clk[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
      end
    end else begin
      int ach;
      bit took;
      ach = int'(Cfg_ch);
      took = Cfg_valid && (ach >= NCH || !m_pend[ach]);
      mdl_acc = took;
      for (int c = 0; c < NCH; c++) begin
        int dm_old, dm, pm;
        bit prev;
        dm_old = eff_d(m_div[c]);
        if (m_pend[c] && (!m_run[c] || !En[c] || Sync || m_q[c] == dm_old - 1)) begin
          m_div[c] = s_div[c]; m_high[c] = s_high[c]; m_ph[c] = s_ph[c];
          m_pend[c] = 0;
        end
        dm = eff_d(m_div[c]);
        pm = (m_ph[c] < dm) ? m_ph[c] : 0;
        if (m_run[c] && En[c]) m_q[c] = Sync ? pm : (m_q[c] + 1) % dm_old;
        else if (En[c])        m_q[c] = pm;
        else                   m_q[c] = 0;
        m_run[c] = En[c];
        if (took && ach == c) begin
          s_div[c] = int'(Cfg_div); s_high[c] = int'(Cfg_high); s_ph[c] = int'(Cfg_phase);
          m_pend[c] = 1;
        end
        prev = m_clk[c];
        m_clk[c]  = m_run[c] && (m_q[c] < m_high[c]);
        m_rise[c] = m_clk[c] && !prev;
        m_fall[c] = !m_clk[c] && prev;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [NCH-1:0] e_clk, e_rise, e_fall, e_pend;
    int ach;
    logic e_rdy;
    @(posedge Clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_clk[c] = m_clk[c]; e_rise[c] = m_rise[c]; e_fall[c] = m_fall[c]; e_pend[c] = m_pend[c];
    end
    ach = int'(Cfg_ch);
    e_rdy = (ach >= NCH) ? 1'b1 : !m_pend[ach];
    check($sformatf("ClkOut@%0t", $time), int'(ClkOut), int'(e_clk));
    check($sformatf("RiseTick@%0t", $time), int'(RiseTick), int'(e_rise));
    check($sformatf("FallTick@%0t", $time), int'(FallTick), int'(e_fall));
    check($sformatf("Pending@%0t", $time), int'(Pending), int'(e_pend));
    check($sformatf("Cfg_ready@%0t", $time), int'(Cfg_ready), int'(e_rdy));
  end

  // ---------------- helpers ----------------
  task automatic cfg_write(input int ch, input int d, input int h, input int p, output int waited);
    @(negedge Clk);
    Cfg_valid = 1'b1; Cfg_ch = CH_W'(ch);
    Cfg_div = 16'(d); Cfg_high = 16'(h); Cfg_phase = 16'(p);
    waited = 0;
    do begin
      @(posedge Clk); #1;
      waited++;
    end while (!mdl_acc && waited < 3000);
    total++;
    if (!mdl_acc) begin
      bad++;
      $display("FAIL cfg_write ch%0d: not accepted after %0d cycles, expected acceptance", ch, waited);
    end
    @(negedge Clk);
    Cfg_valid = 1'b0;
  endtask

  // kind: 0 = ClkOut high, 1 = RiseTick, 2 = Pending clear
  task automatic wait_sig(input int kind, input int ch, input string nm);
    bit hit;
    hit = 0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(posedge Clk); #1;
      case (kind)
        0:       hit = ClkOut[ch];
        1:       hit = RiseTick[ch];
        default: hit = !Pending[ch];
      endcase
    end
    check({"wait ", nm}, int'(hit), 1);
  endtask

  task automatic measure(input int n, input int ch, output int hi, output int ri, output int fa);
    hi = 0; ri = 0; fa = 0;
    repeat (n) begin
      @(posedge Clk); #1;
      hi += int'(ClkOut[ch]); ri += int'(RiseTick[ch]); fa += int'(FallTick[ch]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, hi, ri, fa, mism;
    int a0[30], a1[30];

    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset ClkOut", int'(ClkOut), 0);
    check("reset Pending", int'(Pending), 0);
    check("reset Cfg_ready", int'(Cfg_ready), 1);
    @(negedge Clk) Reset = 1'b1;

    // basic divide: ch0 10/4 configured while stopped
    cfg_write(0, 10, 4, 0, w);
    En = 2'b01;
    repeat (5) @(posedge Clk);
    measure(30, 0, hi, ri, fa);
    check("div10 high cycles", hi, 12);
    check("div10 rise ticks", ri, 3);
    check("div10 fall ticks", fa, 3);
    measure(20, 1, hi, ri, fa);
    check("idle ch1 high cycles", hi, 0);

    // mid-period reconfiguration
    wait_sig(1, 0, "rise ch0");
    cfg_write(0, 6, 3, 0, w);
    check("midwrite Pending[0]", int'(Pending[0]), 1);
    check("midwrite Cfg_ready", int'(Cfg_ready), 0);
    cfg_write(0, 6, 3, 0, w);
    check("second write stalled", int'(w >= 2), 1);
    wait_sig(2, 0, "pending clear ch0");
    measure(30, 0, hi, ri, fa);
    check("div6 high cycles", hi, 15);
    check("div6 rise ticks", ri, 5);

    // sync with phase offset
    cfg_write(1, 10, 5, 5, w);
    cfg_write(0, 10, 5, 0, w);
    @(negedge Clk);
    En = 2'b11; Sync = 1'b1;
    @(posedge Clk); #1;
    check("sync ClkOut", int'(ClkOut), 1);
    @(negedge Clk) Sync = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge Clk); #1;
      a0[t] = int'(ClkOut[0]); a1[t] = int'(ClkOut[1]);
    end
    mism = 0;
    for (int t = 5; t < 30; t++) if (a1[t] != a0[t-5]) mism++;
    check("ch1 lags ch0 by 5 (mismatching cycles)", mism, 0);

    // degenerate configs
    cfg_write(0, 10, 0, 0, w);
    cfg_write(1, 10, 12, 0, w);
    wait_sig(2, 0, "pending clear ch0");
    wait_sig(2, 1, "pending clear ch1");
    repeat (2) @(posedge Clk);
    measure(20, 0, hi, ri, fa);
    check("high0 high cycles", hi, 0);
    check("high0 rise ticks", ri, 0);
    measure(20, 1, hi, ri, fa);
    check("high12 high cycles", hi, 20);
    check("high12 rise ticks", ri, 0);
    cfg_write(0, 1, 1, 0, w);
    wait_sig(2, 0, "pending clear ch0");
    measure(20, 0, hi, ri, fa);
    check("div1 high cycles", hi, 10);
    check("div1 rise ticks", ri, 10);

    // En drop coinciding with Sync while high
    cfg_write(0, 10, 5, 0, w);
    wait_sig(2, 0, "pending clear ch0");
    wait_sig(1, 0, "rise ch0");
    @(negedge Clk);
    En = 2'b10; Sync = 1'b1;
    @(posedge Clk); #1;
    check("stop FallTick[0]", int'(FallTick[0]), 1);
    check("stop ClkOut[0]", int'(ClkOut[0]), 0);
    @(negedge Clk) Sync = 1'b0;
    measure(20, 0, hi, ri, fa);
    check("stopped high cycles", hi, 0);
    check("stopped fall ticks", fa, 0);

    // async reset mid-high with a pending write
    cfg_write(0, 10, 5, 0, w);
    @(negedge Clk) En = 2'b11;
    wait_sig(1, 0, "rise ch0");
    cfg_write(0, 20, 10, 0, w);
    check("pre-reset ClkOut[0]", int'(ClkOut[0]), 1);
    check("pre-reset Pending[0]", int'(Pending[0]), 1);
    #2 Reset = 1'b0;
    #1;
    check("async reset ClkOut", int'(ClkOut), 0);
    check("async reset Pending", int'(Pending), 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    measure(1000, 0, hi, ri, fa);
    check("default high cycles", hi, DHI);
    check("default rise ticks", ri, 1);
    check("default fall ticks", fa, 1);

    // random traffic, checked every cycle by the model compare
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge Clk);
      Sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) En = NCH'($urandom);
      if (Cfg_valid && mdl_acc) Cfg_valid = 1'b0;
      if (!Cfg_valid && $urandom_range(0, 7) == 0) begin
        Cfg_valid = 1'b1;
        Cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
        Cfg_div   = 16'($urandom_range(0, 12));
        Cfg_high  = 16'($urandom_range(0, 14));
        Cfg_phase = 16'($urandom_range(0, 14));
      end
    end
    @(negedge Clk);
    Cfg_valid = 1'b0; Sync = 1'b0;
    repeat (3) @(posedge Clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
